// File: rtl/dual_issue_fetch_buffer.sv
// Circular instruction queue that presents its two oldest entries as an issue pair
// to dual-issue decode, retiring one or two per cycle and dropping all on redirect.
module dual_issue_fetch_buffer #(
    parameter int els_p         = 4,
    parameter int instr_width_p = 32,
    parameter int pc_width_p    = 22
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                v_i,
    input  logic [instr_width_p-1:0]            instr_i,
    input  logic [pc_width_p-1:0]               pc_i,
    output logic                                ready_o,
    input  logic                                flush_i,
    output logic [1:0]                          v_o,
    output logic [1:0][instr_width_p-1:0]       instr_o,
    output logic [1:0][pc_width_p-1:0]          pc_o,
    input  logic                                yumi_i,
    input  logic                                single_issue_i,
    output logic [$clog2(els_p+1)-1:0]          count_o
);
    localparam int PTR_W = $clog2(els_p);
    localparam int CNT_W = $clog2(els_p + 1);
    localparam logic [CNT_W-1:0]         FULL = CNT_W'(els_p);
    localparam logic [instr_width_p-1:0] NOP  = instr_width_p'(32'h0000_0013);

    logic [instr_width_p-1:0] r_instr_mem [els_p];
    logic [pc_width_p-1:0]    r_pc_mem    [els_p];
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [CNT_W-1:0]         r_count;

    logic                     w_enq;
    logic [1:0]               w_pop_n;
    logic [1:0]               w_v;
    logic [PTR_W-1:0]         w_rd_ptr1;
    logic [CNT_W-1:0]         w_count_next;

    // Acceptance looks only at registered occupancy, so a full buffer refuses
    // an enqueue even when decode frees entries on the same edge.
    assign ready_o   = reset_n_i & (r_count < FULL);
    assign w_enq     = v_i & ready_o & ~flush_i;
    assign w_v[0]    = (r_count >= CNT_W'(1));
    assign w_v[1]    = (r_count >= CNT_W'(2));
    assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);

    assign v_o        = w_v;
    assign count_o    = r_count;
    assign instr_o[0] = w_v[0] ? r_instr_mem[r_rd_ptr]  : NOP;
    assign instr_o[1] = w_v[1] ? r_instr_mem[w_rd_ptr1] : NOP;
    assign pc_o[0]    = w_v[0] ? r_pc_mem[r_rd_ptr]     : '0;
    assign pc_o[1]    = w_v[1] ? r_pc_mem[w_rd_ptr1]    : '0;

    always_comb begin
        w_pop_n = 2'd0;
        if (yumi_i && w_v[0]) begin
            w_pop_n = (single_issue_i || !w_v[1]) ? 2'd1 : 2'd2;
        end
    end

    assign w_count_next = r_count + CNT_W'(w_enq) - CNT_W'(w_pop_n);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Storage is data only; its contents are masked by v_o until written.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_instr_mem[r_wr_ptr] <= instr_i;
            r_pc_mem[r_wr_ptr]    <= pc_i;
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        r_count <= FULL);
    a_enq_ready: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        w_enq |-> (r_count < FULL));
    a_pop_le_count: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        CNT_W'(w_pop_n) <= r_count);

endmodule

// File: tb/tb_dual_issue_fetch_buffer.sv
// Bench for dual_issue_fetch_buffer: directed vector table, async-reset sequence,
// then random traffic against a queue-based reference model.
module tb_dual_issue_fetch_buffer;
    localparam int ELS = 4;
    localparam int IW  = 32;
    localparam int PW  = 22;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           v = 1'b0, flush = 1'b0, yumi = 1'b0, single = 1'b0;
    logic [IW-1:0]  instr = '0;
    logic [PW-1:0]  pc = '0;
    logic           ready;
    logic [1:0]     v_o;
    logic [1:0][IW-1:0] instr_o;
    logic [1:0][PW-1:0] pc_o;
    logic [2:0]     count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [IW-1:0] instr;
        logic [PW-1:0] pc;
    } entry_t;
    entry_t q[$];

    typedef struct {
        logic          v;
        logic [PW-1:0] pc;
        logic          flush, yumi, single;
        logic [1:0]    ev;
        logic [2:0]    ecnt;
        logic [PW-1:0] epc0, epc1;
        logic          erdy;
    } vec_t;
    vec_t tbl[24];

    dual_issue_fetch_buffer #(.els_p(ELS), .instr_width_p(IW), .pc_width_p(PW)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .instr_i(instr), .pc_i(pc),
        .ready_o(ready), .flush_i(flush), .v_o(v_o), .instr_o(instr_o), .pc_o(pc_o),
        .yumi_i(yumi), .single_issue_i(single), .count_o(count)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] tag(input logic [PW-1:0] p);
        return 32'hA000_0000 | IW'(p);
    endfunction

    task automatic check(input string name, input logic [1:0] ev, input logic [2:0] ec,
                         input logic [PW-1:0] ep0, input logic [PW-1:0] ep1,
                         input logic [IW-1:0] ei0, input logic [IW-1:0] ei1, input logic er);
        n_vec++;
        if (v_o !== ev || count !== ec || ready !== er || pc_o[0] !== ep0 || pc_o[1] !== ep1 ||
            instr_o[0] !== ei0 || instr_o[1] !== ei1) begin
            n_err++;
            $display("FAIL %s: got v=%b cnt=%0d rdy=%b pc=%h/%h ins=%h/%h, want v=%b cnt=%0d rdy=%b pc=%h/%h ins=%h/%h",
                     name, v_o, count, ready, pc_o[0], pc_o[1], instr_o[0], instr_o[1],
                     ev, ec, er, ep0, ep1, ei0, ei1);
        end
    endtask

    task automatic model_check(input string name);
        int sz = q.size();
        logic [1:0]    ev = {sz >= 2, sz >= 1};
        logic [PW-1:0] p0 = (sz >= 1) ? q[0].pc : '0;
        logic [PW-1:0] p1 = (sz >= 2) ? q[1].pc : '0;
        logic [IW-1:0] i0 = (sz >= 1) ? q[0].instr : 32'h13;
        logic [IW-1:0] i1 = (sz >= 2) ? q[1].instr : 32'h13;
        check(name, ev, 3'(sz), p0, p1, i0, i1, sz < ELS);
    endtask

    // Advance one clock with current inputs, updating the reference queue.
    task automatic step();
        int  sz = q.size();
        int  popn;
        bit  enq;
        enq  = v && (sz < ELS);
        popn = (!yumi || sz == 0) ? 0 : ((single || sz < 2) ? 1 : 2);
        if (flush) begin
            q.delete();
        end else begin
            repeat (popn) void'(q.pop_front());
            if (enq) q.push_back('{instr, pc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic row(input int i, input logic rv, input logic [PW-1:0] rpc, input logic rf,
                       input logic ry, input logic rs, input logic [1:0] ev, input logic [2:0] ec,
                       input logic [PW-1:0] e0, input logic [PW-1:0] e1, input logic er);
        tbl[i] = '{rv, rpc, rf, ry, rs, ev, ec, e0, e1, er};
    endtask

    initial begin
        row( 0, 1, 'h10, 0, 0, 0, 2'b01, 1, 'h10, 'h00, 1);
        row( 1, 1, 'h11, 0, 0, 0, 2'b11, 2, 'h10, 'h11, 1);
        row( 2, 1, 'h12, 0, 0, 0, 2'b11, 3, 'h10, 'h11, 1);
        row( 3, 1, 'h13, 0, 0, 0, 2'b11, 4, 'h10, 'h11, 0);
        row( 4, 0, 'h00, 0, 1, 0, 2'b11, 2, 'h12, 'h13, 1);
        row( 5, 0, 'h00, 0, 1, 1, 2'b01, 1, 'h13, 'h00, 1);
        row( 6, 1, 'h14, 0, 0, 0, 2'b11, 2, 'h13, 'h14, 1);
        row( 7, 1, 'h15, 0, 0, 0, 2'b11, 3, 'h13, 'h14, 1);
        row( 8, 1, 'h16, 0, 0, 0, 2'b11, 4, 'h13, 'h14, 0);
        row( 9, 1, 'h17, 0, 1, 0, 2'b11, 2, 'h15, 'h16, 1);
        row(10, 1, 'h17, 0, 0, 0, 2'b11, 3, 'h15, 'h16, 1);
        row(11, 0, 'h00, 0, 1, 1, 2'b11, 2, 'h16, 'h17, 1);
        row(12, 0, 'h00, 0, 1, 1, 2'b01, 1, 'h17, 'h00, 1);
        row(13, 1, 'h18, 0, 0, 0, 2'b11, 2, 'h17, 'h18, 1);
        row(14, 0, 'h00, 0, 1, 0, 2'b00, 0, 'h00, 'h00, 1);
        row(15, 1, 'h20, 0, 0, 0, 2'b01, 1, 'h20, 'h00, 1);
        row(16, 1, 'h21, 0, 0, 0, 2'b11, 2, 'h20, 'h21, 1);
        row(17, 1, 'h22, 0, 0, 0, 2'b11, 3, 'h20, 'h21, 1);
        row(18, 1, 'h23, 1, 1, 0, 2'b00, 0, 'h00, 'h00, 1);
        row(19, 1, 'h40, 0, 0, 0, 2'b01, 1, 'h40, 'h00, 1);
        row(20, 0, 'h00, 0, 1, 0, 2'b00, 0, 'h00, 'h00, 1);
        row(21, 0, 'h00, 0, 1, 0, 2'b00, 0, 'h00, 'h00, 1);
        row(22, 1, 'h41, 0, 1, 0, 2'b01, 1, 'h41, 'h00, 1);
        row(23, 1, 'h42, 0, 1, 1, 2'b01, 1, 'h42, 'h00, 1);

        // Reset held, then released between edges.
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 2'b00, 0, '0, '0, 32'h13, 32'h13, 1'b0);
        reset_n = 1'b1;
        #1;
        check("reset_release", 2'b00, 0, '0, '0, 32'h13, 32'h13, 1'b1);

        for (int i = 0; i < 24; i++) begin
            v = tbl[i].v; pc = tbl[i].pc; instr = tag(tbl[i].pc);
            flush = tbl[i].flush; yumi = tbl[i].yumi; single = tbl[i].single;
            step();
            check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ecnt, tbl[i].epc0, tbl[i].epc1,
                  tbl[i].ev[0] ? tag(tbl[i].epc0) : 32'h13,
                  tbl[i].ev[1] ? tag(tbl[i].epc1) : 32'h13, tbl[i].erdy);
        end

        // Async reset mid-cycle with three entries present.
        yumi = 1'b0; single = 1'b0; flush = 1'b0;
        v = 1'b1; pc = 'h50; instr = tag('h50); step();
        pc = 'h51; instr = tag('h51); step();
        v = 1'b0;
        model_check("pre_async_reset");
        #3;
        reset_n = 1'b0;
        #1;
        q.delete();
        check("async_reset", 2'b00, 0, '0, '0, 32'h13, 32'h13, 1'b0);
        #2;
        reset_n = 1'b1;
        #1;
        check("async_release", 2'b00, 0, '0, '0, 32'h13, 32'h13, 1'b1);

        for (int i = 0; i < 600; i++) begin
            v      = ($urandom_range(0, 9) < 7);
            pc     = PW'($urandom);
            instr  = $urandom;
            flush  = ($urandom_range(0, 39) == 0);
            yumi   = ($urandom_range(0, 1) == 1);
            single = ($urandom_range(0, 1) == 1);
            step();
            model_check($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
